// File: rtl/input_load_ctrl_pkg.sv
// Shared types and defaults for the systolic input-load sequencer.
// Holds the FSM state enum, default sizes and the counter width helper.
package input_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SRC,
    WAIT_ACK,
    ADVANCE,
    WAIT_LOAD,
    FEED,
    DONE
  } state_e;

  localparam int DEF_N_BEATS        = 4;
  localparam int DEF_FEED_CYCLES    = 10;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_load_ctrl_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting, flags expiry, sticky err.
// Ports: clk, reset (sync, active-low), waiting, clr, start_acc -> expire, err.
module input_ctrl_watchdog
  import input_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clr,
  input  logic start_acc,
  output logic expire,
  output logic err
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt;

  // The cycle with cnt at LIMIT-1 is the LIMIT-th waiting cycle.
  assign expire = waiting && (cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || !waiting) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (expire) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/input_load_ctrl.sv
// Input-load sequencer: source handshake, row/col stepping, array feed window.
// Ports: clk, reset(sync low), start, src_valid, tx_one_done, load_done in;
//   dest_ready, next_row, next_col, array_en, busy, done, beat_cnt, err out.
// Optional watchdog: define INPUT_LOAD_CTRL_TIMEOUT_EN.
module input_load_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int N_BEATS        = DEF_N_BEATS,
  parameter int FEED_CYCLES    = DEF_FEED_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      src_valid,
  output logic                      dest_ready,
  input  logic                      tx_one_done,
  output logic                      next_row,
  output logic                      next_col,
  input  logic                      load_done,
  output logic                      array_en,
  output logic                      busy,
  output logic                      done,
  output logic [cnt_w(N_BEATS)-1:0] beat_cnt,
  output logic                      err
);

  localparam int BW = cnt_w(N_BEATS);
  localparam int FW = cnt_w(FEED_CYCLES);

  state_e        state_q;
  state_e        state_d;
  logic [FW-1:0] feed_cnt;
  logic          expire;
  logic          start_acc;
  logic          last_beat;
  logic          feed_last;

  assign start_acc = (state_q == IDLE) && start;
  assign last_beat = beat_cnt == BW'(N_BEATS - 1);
  assign feed_last = feed_cnt == FW'(FEED_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start)       state_d = WAIT_SRC;
      WAIT_SRC:  if (src_valid)   state_d = WAIT_ACK;
      WAIT_ACK:  if (tx_one_done) state_d = ADVANCE;
      ADVANCE:   state_d = last_beat ? WAIT_LOAD : WAIT_SRC;
      WAIT_LOAD: if (load_done)   state_d = FEED;
      FEED:      if (feed_last)   state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Watchdog abort outranks any wait-state exit.
    if (expire) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (start_acc) begin
      beat_cnt <= '0;
    end else if (state_q == ADVANCE && beat_cnt != BW'(N_BEATS)) begin
      beat_cnt <= beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      feed_cnt <= '0;
    end else if (state_q == WAIT_LOAD) begin
      feed_cnt <= '0;
    end else if (state_q == FEED) begin
      feed_cnt <= feed_cnt + FW'(1);
    end
  end

  assign dest_ready = state_q == WAIT_SRC;
  assign next_row   = state_q == ADVANCE;
  assign next_col   = state_q == ADVANCE;
  assign array_en   = state_q == FEED;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;

`ifdef INPUT_LOAD_CTRL_TIMEOUT_EN
  logic waiting;
  logic chg;

  assign waiting = (state_q == WAIT_SRC) ||
                   (state_q == WAIT_ACK) ||
                   (state_q == WAIT_LOAD);
  assign chg     = state_d != state_q;

  input_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .clr      (chg),
    .start_acc(start_acc),
    .expire   (expire),
    .err      (err)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_input_load_ctrl.sv
// Directed self-checking bench for input_load_ctrl.
// Watchdog steps run when INPUT_LOAD_CTRL_TIMEOUT_EN is defined.
module tb_input_load_ctrl;

  localparam int NB = 4;
  localparam int FC = 10;
  localparam int TO = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic       src_valid;
  logic       dest_ready;
  logic       tx_one_done;
  logic       next_row;
  logic       next_col;
  logic       load_done;
  logic       array_en;
  logic       busy;
  logic       done;
  logic [2:0] beat_cnt;
  logic       err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int rows_n = 0;
  int cols_n = 0;
  int en_n   = 0;
  int done_n = 0;
  int consec = 0;
  int unpair = 0;
  logic row_prev = 1'b0;

  int r0, k0, e0, d0, c0, dcyc;

  input_load_ctrl #(
    .N_BEATS       (NB),
    .FEED_CYCLES   (FC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_valid  (src_valid),
    .dest_ready (dest_ready),
    .tx_one_done(tx_one_done),
    .next_row   (next_row),
    .next_col   (next_col),
    .load_done  (load_done),
    .array_en   (array_en),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, required finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (next_row) rows_n++;
    if (next_col) cols_n++;
    if (array_en) en_n++;
    if (done) done_n++;
    if (next_row && row_prev) consec++;
    if (next_row != next_col) unpair++;
    row_prev <= next_row;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    r0 = rows_n;
    k0 = cols_n;
    e0 = en_n;
    d0 = done_n;
  endtask

  task automatic beat(input int gap, input bit spur, input int n);
    chk("ws_ready", dest_ready, 1);
    if (gap > 0) begin
      src_valid   = 1'b0;
      tx_one_done = spur;
      for (int i = 0; i < gap; i++) begin
        tick();
        chk("gap_ready", dest_ready, 1);
        chk("gap_cnt", beat_cnt, n);
        chk("gap_row", next_row, 0);
      end
      tx_one_done = 1'b0;
    end
    src_valid = 1'b1;
    tick();
    chk("ack_ready", dest_ready, 0);
    chk("ack_row", next_row, 0);
    tx_one_done = 1'b1;
    tick();
    chk("adv_row", next_row, 1);
    chk("adv_col", next_col, 1);
    tx_one_done = 1'b0;
    tick();
    chk("beat_cnt", beat_cnt, n + 1);
    chk("post_row", next_row, 0);
  endtask

  task automatic feed(input bit spur_start, output int dc);
    chk("wl_cnt", beat_cnt, NB);
    chk("wl_ready", dest_ready, 0);
    chk("wl_en", array_en, 0);
    chk("wl_busy", busy, 1);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int i = 0; i < FC; i++) begin
      chk("feed_en", array_en, 1);
      chk("feed_done", done, 0);
      start = spur_start && (i == 4);
      tick();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_en", array_en, 0);
    dc = cyc;
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b1;
    src_valid   = 1'b1;
    tx_one_done = 1'b1;
    load_done   = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", dest_ready, 0);
    chk("rst_row", next_row, 0);
    chk("rst_col", next_col, 0);
    chk("rst_en", array_en, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_err", err, 0);

    start       = 1'b0;
    src_valid   = 1'b0;
    tx_one_done = 1'b0;
    load_done   = 1'b0;
    reset       = 1'b1;
    tick();
    chk("rel_busy", busy, 0);
    tick();
    chk("rel_busy2", busy, 0);

    // nominal run, source always valid
    snap();
    c0        = cyc;
    src_valid = 1'b1;
    start     = 1'b1;
    chk("idle_ready", dest_ready, 0);
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
    for (int b = 0; b < NB; b++) beat(0, 1'b0, b);
    feed(1'b0, dcyc);
    chk("run_len", dcyc - c0 + 1, 25);
    chk("nom_rows", rows_n - r0, NB);
    chk("nom_cols", cols_n - k0, NB);
    chk("nom_en", en_n - e0, FC);
    chk("nom_done", done_n - d0, 1);
    chk("hold_cnt", beat_cnt, NB);
    chk("nom_err", err, 0);

    // back-pressure, spurious ack, start during FEED
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_cnt0", beat_cnt, 0);
    beat(0, 1'b0, 0);
    beat(0, 1'b0, 1);
    beat(7, 1'b0, 2);
    beat(3, 1'b1, 3);
    feed(1'b1, dcyc);
    tick();
    chk("spur_busy", busy, 0);
    chk("bp_rows", rows_n - r0, NB);
    chk("bp_en", en_n - e0, FC);
    chk("bp_done", done_n - d0, 1);

    // reset in WAIT_ACK of beat 2
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    beat(0, 1'b0, 0);
    src_valid = 1'b1;
    tick();
    chk("mr_ack", dest_ready, 0);
    reset = 1'b0;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_cnt", beat_cnt, 0);
    reset     = 1'b1;
    src_valid = 1'b0;
    tick();
    chk("mr_idle", busy, 0);
    chk("mr_done", done_n - d0, 0);
    chk("mr_rows", rows_n - r0, 1);

`ifdef INPUT_LOAD_CTRL_TIMEOUT_EN
    snap();
    src_valid = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < NB; b++) beat(0, 1'b0, b);
    chk("wd_entry", busy, 1);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("wd_busy", busy, 1);
      chk("wd_err0", err, 0);
    end
    tick();
    chk("wd_idle", busy, 0);
    chk("wd_err", err, 1);
    chk("wd_en", array_en, 0);
    tick();
    chk("wd_sticky", err, 1);
    chk("wd_done", done_n - d0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_clr", err, 0);
    chk("wd_busy2", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
`endif

    chk("pair", unpair, 0);
    chk("consec", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
